// File: rtl/pc_return_stack_if.sv
// pc_return_stack_if
// Bundles the push/pop request side and the status side of the return-address
// stack so the core and the stack agree on one set of widths.
//   master (core)  : drives push, pop, push_data, clear_err;
//                    observes top, count, empty, full, overflow, underflow
//   slave  (stack) : the mirror image of master
interface pc_return_stack_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DEPTH      = 8
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_data;
    logic                  clear_err;
    logic [ADDR_WIDTH-1:0] top;
    logic [CNT_WIDTH-1:0]  count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, push_data, clear_err,
        input  top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, clear_err,
        output top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/pc_return_stack.sv
// pc_return_stack
// Return-address stack between the PC and the PC adder mux. CALL pushes the
// current PC, RET pops it back. Push and pop in the same cycle replaces the
// top entry (tail call). Overflow/underflow are sticky until clear_err/rst.
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_return_stack_if.slave (push/pop/push_data/clear_err in,
//          top/count/empty/full/overflow/underflow out)
// All outputs come from registered state only.
module pc_return_stack #(
    parameter int ADDR_WIDTH = 18,
    parameter int DEPTH      = 8,
    parameter int WRAP_MODE  = 0
) (
    input  logic           clk,
    input  logic           rst,
    pc_return_stack_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam int SP_WIDTH  = $clog2(DEPTH);
    localparam logic [SP_WIDTH-1:0]  SP_LAST  = SP_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [SP_WIDTH-1:0]   sp, sp_next, sp_inc, sp_dec, waddr;
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic                  overflow, underflow, ov_next, un_next;
    logic                  we, is_empty, is_full;

    // DEPTH need not be a power of two, so wrap the pointer explicitly.
    assign sp_inc   = (sp == SP_LAST) ? '0 : sp + SP_WIDTH'(1);
    assign sp_dec   = (sp == '0) ? SP_LAST : sp - SP_WIDTH'(1);
    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);

    always_comb begin
        sp_next    = sp;
        count_next = count;
        we         = 1'b0;
        waddr      = sp;
        // A new error event in the same cycle as clear_err wins below.
        ov_next    = overflow & ~bus.clear_err;
        un_next    = underflow & ~bus.clear_err;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (!is_full) begin
                    we         = 1'b1;
                    sp_next    = sp_inc;
                    count_next = count + CNT_WIDTH'(1);
                end else begin
                    ov_next = 1'b1;
                    if (WRAP_MODE != 0) begin
                        // Circular: overwrite the oldest slot, count stays full.
                        we      = 1'b1;
                        sp_next = sp_inc;
                    end
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    sp_next    = sp_dec;
                    count_next = count - CNT_WIDTH'(1);
                end else begin
                    un_next = 1'b1;
                end
            end
            2'b11: begin
                we = 1'b1;
                if (is_empty) begin
                    sp_next    = sp_inc;
                    count_next = CNT_WIDTH'(1);
                end else begin
                    // Tail call: replace top in place.
                    waddr = sp_dec;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            count     <= count_next;
            overflow  <= ov_next;
            underflow <= un_next;
        end
    end

    // Entry storage is deliberately not reset; top is masked while empty.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= bus.push_data;
        end
    end

    assign bus.top       = is_empty ? '0 : mem[sp_dec];
    assign bus.count     = count;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;
    localparam int AW = 18;
    localparam int DP = 4;

    typedef logic [AW-1:0] addr_q_t [$];
    typedef struct {
        logic [AW-1:0] top;
        int            count;
        bit            empty;
        bit            full;
        bit            ov;
        bit            un;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_return_stack_if #(.ADDR_WIDTH(AW), .DEPTH(DP)) bus0 ();
    pc_return_stack_if #(.ADDR_WIDTH(AW), .DEPTH(DP)) bus1 ();

    pc_return_stack #(.ADDR_WIDTH(AW), .DEPTH(DP), .WRAP_MODE(0)) dut_drop (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    pc_return_stack #(.ADDR_WIDTH(AW), .DEPTH(DP), .WRAP_MODE(1)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    addr_q_t stk0, stk1;
    bit ov0, un0, ov1, un1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the stack is a queue of addresses, newest at the back.
    task automatic model(input bit wrap, input bit r, input bit p, input bit o,
                         input logic [AW-1:0] d, input bit c,
                         input addr_q_t qi, input bit ovi, input bit uni,
                         output addr_q_t qo, output bit ovo, output bit uno);
        addr_q_t q;
        q = qi; ovo = ovi; uno = uni;
        if (r) begin
            q = {}; ovo = 0; uno = 0;
        end else begin
            if (c) begin ovo = 0; uno = 0; end
            if (p && o) begin
                if (q.size() == 0) q.push_back(d);
                else q[q.size()-1] = d;
            end else if (p) begin
                if (q.size() < DP) q.push_back(d);
                else begin
                    ovo = 1;
                    if (wrap) begin
                        void'(q.pop_front());
                        q.push_back(d);
                    end
                end
            end else if (o) begin
                if (q.size() > 0) void'(q.pop_back());
                else uno = 1;
            end
        end
        qo = q;
    endtask

    function automatic exp_t mk_exp(input addr_q_t q, input bit ov, input bit un);
        exp_t e;
        e.top   = (q.size() > 0) ? q[q.size()-1] : '0;
        e.count = q.size();
        e.empty = (q.size() == 0);
        e.full  = (q.size() == DP);
        e.ov    = ov;
        e.un    = un;
        return e;
    endfunction

    task automatic step(input bit r, input bit p, input bit o,
                        input logic [AW-1:0] d, input bit c);
        @(negedge clk);
        rst = r;
        bus0.push = p; bus0.pop = o; bus0.push_data = d; bus0.clear_err = c;
        bus1.push = p; bus1.pop = o; bus1.push_data = d; bus1.clear_err = c;
        model(1'b0, r, p, o, d, c, stk0, ov0, un0, stk0, ov0, un0);
        model(1'b1, r, p, o, d, c, stk1, ov1, un1, stk1, ov1, un1);
        exp_q0.push_back(mk_exp(stk0, ov0, un0));
        exp_q1.push_back(mk_exp(stk1, ov1, un1));
    endtask

    // Monitor: outputs are valid every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                chk("drop.top",   32'(bus0.top),       32'(e.top));
                chk("drop.count", 32'(bus0.count),     32'(e.count));
                chk("drop.empty", 32'(bus0.empty),     32'(e.empty));
                chk("drop.full",  32'(bus0.full),      32'(e.full));
                chk("drop.ovf",   32'(bus0.overflow),  32'(e.ov));
                chk("drop.unf",   32'(bus0.underflow), 32'(e.un));
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                chk("wrap.top",   32'(bus1.top),       32'(e.top));
                chk("wrap.count", 32'(bus1.count),     32'(e.count));
                chk("wrap.empty", 32'(bus1.empty),     32'(e.empty));
                chk("wrap.full",  32'(bus1.full),      32'(e.full));
                chk("wrap.ovf",   32'(bus1.overflow),  32'(e.ov));
                chk("wrap.unf",   32'(bus1.underflow), 32'(e.un));
            end
        end
    end

    initial begin
        int r;
        bit p, o, c, rr;
        rst = 1'b1;
        bus0.push = 0; bus0.pop = 0; bus0.push_data = '0; bus0.clear_err = 0;
        bus1.push = 0; bus1.pop = 0; bus1.push_data = '0; bus1.clear_err = 0;
        ov0 = 0; un0 = 0; ov1 = 0; un1 = 0;

        // Reset then idle
        step(1, 0, 0, '0, 0);
        repeat (5) step(0, 0, 0, '0, 0);

        // LIFO order
        step(0, 1, 0, 18'h00010, 0);
        step(0, 1, 0, 18'h00020, 0);
        step(0, 1, 0, 18'h00030, 0);
        repeat (3) step(0, 0, 1, '0, 0);

        // Overflow drop / wrap: push 1..6 then drain, plus extra pop
        step(1, 0, 0, '0, 0);
        for (int i = 1; i <= 6; i++) step(0, 1, 0, AW'(i), 0);
        repeat (5) step(0, 0, 1, '0, 0);

        // Underflow and clear
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, '0, 0);
        step(0, 0, 1, '0, 1);
        step(0, 0, 0, '0, 1);

        // Simultaneous ops and mid-operation reset
        step(0, 1, 0, 18'h3FFFF, 0);
        step(0, 1, 1, 18'h00123, 0);
        step(0, 0, 1, '0, 0);
        step(0, 1, 1, 18'h00055, 0);
        step(0, 1, 0, 18'h00077, 0);
        step(0, 1, 0, 18'h00099, 0);
        step(1, 1, 0, 18'h00011, 0);
        step(0, 0, 0, '0, 0);

        // Full-stack replace: no error while full
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < DP; i++) step(0, 1, 0, AW'(i + 16), 0);
        step(0, 1, 1, 18'h2ABCD, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            p  = (r < 45) || (r >= 85 && r < 95);
            o  = (r >= 40 && r < 85) || (r >= 90 && r < 95);
            c  = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 149) == 0);
            step(rr, p, o, AW'($urandom), c);
        end

        step(0, 0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
